// File: rtl/drumbank_sweep.sv
// Plugboard hypothesis sweep controller for a chain of external drum stages.
// For each hypothesis it clears the plugboard memory and seeds the two
// letters under test. It then lets the stage chain run until the chain
// faults, completes, or times out.
module drumbank_sweep #(
    parameter int unsigned NUM_STAGES = 12,
    parameter int unsigned DEPTH      = 26,
    parameter int unsigned DATA_W     = 5,
    parameter int unsigned HYP_FIRST  = 0,
    parameter int unsigned HYP_LAST   = 25,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         abort,
    input  logic [DATA_W-1:0]            msg_input0,
    output logic                         busy,
    output logic                         done,
    output logic                         found,
    output logic [DATA_W-1:0]            found_hyp,
    output logic                         timeout_seen,
    output logic [DATA_W-1:0]            hyp_out,
    output logic                         stage_clear,
    output logic [NUM_STAGES-1:0]        stage_enable,
    input  logic [NUM_STAGES-1:0]        stage_done,
    input  logic [NUM_STAGES-1:0]        stage_fault,
    input  logic [NUM_STAGES-1:0]        stage_we,
    input  logic [5*NUM_STAGES-1:0]      stage_waddr,
    input  logic [5*NUM_STAGES-1:0]      stage_raddr,
    input  logic [DATA_W*NUM_STAGES-1:0] stage_wdata,
    output logic [DATA_W-1:0]            stage_rdata
);

    localparam int unsigned AW   = 5;
    localparam int unsigned CntW = $clog2(NUM_STAGES + 1);
    localparam int unsigned ActW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam int unsigned TmW  = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StWrite0,
        StWrite1,
        StRun,
        StNext,
        StFinish
    } state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   msg_q, msg_d;
    logic [DATA_W-1:0]   hyp_q, hyp_d;
    logic [DATA_W-1:0]   found_hyp_q, found_hyp_d;
    logic                found_q, found_d;
    logic                tmo_q, tmo_d;
    logic [AW-1:0]       clr_cnt_q, clr_cnt_d;
    logic [TmW-1:0]      run_cnt_q, run_cnt_d;
    logic [ActW-1:0]     active_q, active_d;
    logic [CntW-1:0]     done_cnt;
    logic                any_fault;
    logic                all_done;

    logic                mem_we;
    logic [AW-1:0]       mem_waddr;
    logic [AW-1:0]       mem_raddr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DATA_W-1:0]   rdata_q;

    assign any_fault = |stage_fault;
    assign all_done  = &stage_done;

    // Active stage: number of completed stages, saturated at the last stage
    always_comb begin
        done_cnt = '0;
        for (int unsigned i = 0; i < NUM_STAGES; i++) begin
            done_cnt = done_cnt + CntW'(stage_done[i]);
        end
        if (32'(done_cnt) > NUM_STAGES - 1) begin
            active_d = ActW'(NUM_STAGES - 1);
        end else begin
            active_d = ActW'(done_cnt);
        end
    end

    // Stage i may run once its predecessor has completed
    always_comb begin
        stage_enable = '0;
        if (state_q == StRun) begin
            stage_enable[0] = 1'b1;
            for (int unsigned i = 1; i < NUM_STAGES; i++) begin
                stage_enable[i] = stage_done[i-1];
            end
        end
    end

    // Memory port: the active stage owns it in RUN, the controller elsewhere
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_raddr = '0;
        mem_wdata = '0;
        case (state_q)
            StClear: begin
                mem_we    = 1'b1;
                mem_waddr = clr_cnt_q;
                mem_wdata = '1;
            end
            StWrite0: begin
                mem_we    = 1'b1;
                mem_waddr = AW'(msg_q);
                mem_wdata = hyp_q;
            end
            StWrite1: begin
                mem_we    = 1'b1;
                mem_waddr = AW'(hyp_q);
                mem_wdata = msg_q;
            end
            StRun: begin
                mem_we    = stage_we[active_q];
                mem_waddr = stage_waddr[active_q*AW +: AW];
                mem_raddr = stage_raddr[active_q*AW +: AW];
                mem_wdata = stage_wdata[active_q*DATA_W +: DATA_W];
            end
            default: ;
        endcase
    end

    // Plugboard memory: registered read returns pre-write data on a collision
    always_ff @(posedge clk) begin
        if (mem_we && (32'(mem_waddr) < DEPTH)) begin
            mem[mem_waddr] <= mem_wdata;
        end
        rdata_q <= (32'(mem_raddr) < DEPTH) ? mem[mem_raddr] : '0;
    end

    // Sweep sequencing and result bookkeeping
    always_comb begin
        state_d     = state_q;
        msg_d       = msg_q;
        hyp_d       = hyp_q;
        found_d     = found_q;
        found_hyp_d = found_hyp_q;
        tmo_d       = tmo_q;
        clr_cnt_d   = clr_cnt_q;
        run_cnt_d   = run_cnt_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d     = StClear;
                    msg_d       = msg_input0;
                    hyp_d       = DATA_W'(HYP_FIRST);
                    found_d     = 1'b0;
                    found_hyp_d = DATA_W'(HYP_FIRST);
                    tmo_d       = 1'b0;
                    clr_cnt_d   = '0;
                end
            end
            StClear: begin
                clr_cnt_d = clr_cnt_q + AW'(1);
                if (clr_cnt_q == AW'(DEPTH - 1)) begin
                    clr_cnt_d = '0;
                    state_d   = StWrite0;
                end
            end
            StWrite0: state_d = StWrite1;
            StWrite1: begin
                run_cnt_d = '0;
                state_d   = StRun;
            end
            StRun: begin
                run_cnt_d = run_cnt_q + TmW'(1);
                // Fault beats completion, completion beats timeout
                if (any_fault) begin
                    state_d = StNext;
                end else if (all_done) begin
                    found_d     = 1'b1;
                    found_hyp_d = hyp_q;
                    state_d     = StFinish;
                end else if (run_cnt_q == TmW'(TIMEOUT - 1)) begin
                    tmo_d   = 1'b1;
                    state_d = StNext;
                end
            end
            StNext: begin
                if (hyp_q == DATA_W'(HYP_LAST)) begin
                    state_d = StFinish;
                end else begin
                    hyp_d     = hyp_q + DATA_W'(1);
                    clr_cnt_d = '0;
                    state_d   = StClear;
                end
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
        // Abort leaves results exactly as they stood before this cycle
        if (abort && (state_q != StIdle)) begin
            state_d     = StIdle;
            found_d     = found_q;
            found_hyp_d = found_hyp_q;
            tmo_d       = tmo_q;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            msg_q       <= '0;
            hyp_q       <= DATA_W'(HYP_FIRST);
            found_q     <= 1'b0;
            found_hyp_q <= DATA_W'(HYP_FIRST);
            tmo_q       <= 1'b0;
            clr_cnt_q   <= '0;
            run_cnt_q   <= '0;
            active_q    <= '0;
        end else begin
            state_q     <= state_d;
            msg_q       <= msg_d;
            hyp_q       <= hyp_d;
            found_q     <= found_d;
            found_hyp_q <= found_hyp_d;
            tmo_q       <= tmo_d;
            clr_cnt_q   <= clr_cnt_d;
            run_cnt_q   <= run_cnt_d;
            active_q    <= active_d;
        end
    end

    assign busy         = (state_q != StIdle);
    assign done         = (state_q == StFinish);
    assign stage_clear  = (state_q == StClear);
    assign found        = found_q;
    assign found_hyp    = found_hyp_q;
    assign timeout_seen = tmo_q;
    assign hyp_out      = hyp_q;
    assign stage_rdata  = rdata_q;

endmodule
